execute_stage: RTL

Execute pipeline stage between the decode stage and the memory stage. It selects the ALU operands from register data, PC or immediate, and drives one ALU instance combinationally. It resolves branches and jumps from the ALU result and zero flag, and registers the results into the EX/MEM pipeline register. A valid/ready handshake on both sides supports back-pressure, and a one-cycle redirect pulse steers fetch on taken control transfers.

---
 rtl/execute_stage_pkg.sv | 59 +++++
 rtl/execute_stage_if.sv | 52 +++++
 rtl/alu.sv | 32 +++
 rtl/execute_stage_branch_unit.sv | 34 +++
 rtl/execute_stage.sv | 106 ++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared execute-stage types: ALU operator codes, control-transfer kinds,
// operand-select codes and the EX/MEM register layout.
package execute_stage_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;
    localparam int CTRL_W   = 4;
    localparam int REG_W    = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [CTRL_W-1:0] {
        CTRL_NONE = 4'd0,
        CTRL_BEQ  = 4'd1,
        CTRL_BNE  = 4'd2,
        CTRL_BLT  = 4'd3,
        CTRL_BGE  = 4'd4,
        CTRL_BLTU = 4'd5,
        CTRL_BGEU = 4'd6,
        CTRL_JAL  = 4'd7,
        CTRL_JALR = 4'd8
    } ctrl_e;

    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  store_data;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } exmem_t;

    // Encodings beyond JALR are reserved and behave like a plain ALU op.
    function automatic ctrl_e decode_ctrl(input logic [CTRL_W-1:0] raw);
        return (raw <= 4'd8) ? ctrl_e'(raw) : CTRL_NONE;
    endfunction

    function automatic logic is_jump(input ctrl_e c);
        return (c == CTRL_JAL) || (c == CTRL_JALR);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode->execute->memory handshake bundle plus the fetch redirect.
interface execute_stage_if;
    import execute_stage_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_pc;
    logic [XLEN-1:0]     in_rs1_data;
    logic [XLEN-1:0]     in_rs2_data;
    logic [XLEN-1:0]     in_imm;
    logic [ALU_OP_W-1:0] in_alu_op;
    logic                in_op1_sel;
    logic                in_op2_sel;
    logic [CTRL_W-1:0]   in_ctrl;
    logic [REG_W-1:0]    in_rd;
    logic                in_reg_write;
    logic                in_mem_read;
    logic                in_mem_write;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_result;
    logic [XLEN-1:0]     out_store_data;
    logic [REG_W-1:0]    out_rd;
    logic                out_reg_write;
    logic                out_mem_read;
    logic                out_mem_write;

    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;

    // Environment side: decode, memory stage and fetch.
    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm, in_alu_op,
               in_op1_sel, in_op2_sel, in_ctrl, in_rd, in_reg_write,
               in_mem_read, in_mem_write, out_ready,
        input  in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_read, out_mem_write,
               redirect_valid, redirect_pc
    );

    // Execute stage side.
    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm, in_alu_op,
               in_op1_sel, in_op2_sel, in_ctrl, in_rd, in_reg_write,
               in_mem_read, in_mem_write, out_ready,
        output in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_read, out_mem_write,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/alu.sv
// Integer ALU, purely combinational; zero flag reflects the result.
module alu
    import execute_stage_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [XLEN-1:0]     result_o,
    output logic                zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:    result_o = a_i + b_i;
            ALU_SUB:    result_o = a_i - b_i;
            ALU_AND:    result_o = a_i & b_i;
            ALU_OR:     result_o = a_i | b_i;
            ALU_XOR:    result_o = a_i ^ b_i;
            ALU_SLL:    result_o = a_i << b_i[4:0];
            ALU_SRL:    result_o = a_i >> b_i[4:0];
            ALU_SRA:    result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            ALU_SLT:    result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:   result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_PASS_B: result_o = b_i;
            default:    result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_stage_branch_unit.sv
// Branch/jump resolution from the ALU zero flag; target from a private
// pc+imm adder, or the ALU sum with bit 0 cleared for JALR.
module branch_unit
    import execute_stage_pkg::*;
(
    input  ctrl_e           ctrl_i,
    input  logic            zero_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o
);

    logic [XLEN-1:0] pc_rel;

    assign pc_rel = pc_i + imm_i;

    // SLT/SLTU leave 1 in the result when "less than", so !zero means less.
    always_comb begin
        taken_o = 1'b0;
        case (ctrl_i)
            CTRL_BEQ:             taken_o = zero_i;
            CTRL_BNE:             taken_o = !zero_i;
            CTRL_BLT, CTRL_BLTU:  taken_o = !zero_i;
            CTRL_BGE, CTRL_BGEU:  taken_o = zero_i;
            CTRL_JAL, CTRL_JALR:  taken_o = 1'b1;
            default:              taken_o = 1'b0;
        endcase
    end

    assign target_o = (ctrl_i == CTRL_JALR) ? (alu_result_i & ~32'd1) : pc_rel;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand mux, ALU, branch resolution into the EX/MEM register; 1-cycle latency.
// Holds outputs while the memory stage stalls; input refused on stall, redirect pulse or flush.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    execute_stage_if.slave bus
);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic [XLEN-1:0] link_pc;
    ctrl_e           ctrl;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            in_ready;

    exmem_t          exmem_d,     exmem_q;
    logic            out_valid_d, out_valid_q;
    logic            redir_vld_d, redir_vld_q;
    logic [XLEN-1:0] redir_pc_d,  redir_pc_q;

    assign ctrl    = decode_ctrl(bus.in_ctrl);
    assign op1     = (bus.in_op1_sel == OP1_PC)  ? bus.in_pc  : bus.in_rs1_data;
    assign op2     = (bus.in_op2_sel == OP2_IMM) ? bus.in_imm : bus.in_rs2_data;
    assign link_pc = bus.in_pc + 32'd4;

    alu u_alu (
        .op_i     (bus.in_alu_op),
        .a_i      (op1),
        .b_i      (op2),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    branch_unit u_branch (
        .ctrl_i       (ctrl),
        .zero_i       (alu_zero),
        .alu_result_i (alu_result),
        .pc_i         (bus.in_pc),
        .imm_i        (bus.in_imm),
        .taken_o      (taken),
        .target_o     (target)
    );

    // The redirect cycle is the wrong-path slot: refusing it lets decode flush itself.
    assign in_ready = (!out_valid_q || bus.out_ready) && !redir_vld_q && !flush;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        exmem_d     = exmem_q;
        out_valid_d = out_valid_q;
        redir_vld_d = 1'b0;
        redir_pc_d  = redir_pc_q;

        if (flush) begin
            out_valid_d = 1'b0;
            exmem_d     = '0;
        end else if (accept) begin
            out_valid_d          = 1'b1;
            exmem_d.result       = is_jump(ctrl) ? link_pc : alu_result;
            exmem_d.store_data   = bus.in_rs2_data;
            exmem_d.rd           = bus.in_rd;
            exmem_d.reg_write    = bus.in_reg_write && (bus.in_rd != '0);
            exmem_d.mem_read     = bus.in_mem_read;
            exmem_d.mem_write    = bus.in_mem_write;
            if (taken) begin
                redir_vld_d = 1'b1;
                redir_pc_d  = target;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exmem_q     <= '0;
            out_valid_q <= 1'b0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            exmem_q     <= exmem_d;
            out_valid_q <= out_valid_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_result     = exmem_q.result;
    assign bus.out_store_data = exmem_q.store_data;
    assign bus.out_rd         = exmem_q.rd;
    assign bus.out_reg_write  = exmem_q.reg_write;
    assign bus.out_mem_read   = exmem_q.mem_read;
    assign bus.out_mem_write  = exmem_q.mem_write;
    assign bus.redirect_valid = redir_vld_q;
    assign bus.redirect_pc    = redir_pc_q;

endmodule
